ysyx_25040129_icache: RTL and testbench

Direct-mapped, blocking instruction cache placed between the IFU read port and the AXI4 memory bus. It accepts one IFU fetch at a time on a simple AR/R slave channel and answers hits one cycle after the address handshake. Misses are refilled with an INCR burst. A programmable region bypasses the cache with single-beat reads, and fence_i invalidates all lines.

---
 rtl/ysyx_25040129_icache_pkg.sv | 40 ++++
 rtl/ysyx_25040129_icache_data_array.sv | 35 +++
 rtl/ysyx_25040129_icache.sv | 250 +++++++++++++++++++++++++
 tb/tb_ysyx_25040129_icache.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_icache_pkg.sv
// rtl/ysyx_25040129_icache_pkg.sv - shared types, bus constants and geometry helpers for the icache
// Purpose: FSM state encoding, AXI response/burst constants and functions that
//          derive the offset/index/tag/word-select widths from the cache geometry.
// Ports:   none (package).
package ysyx_25040129_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_AR,
        REFILL_R,
        BYPASS_AR,
        BYPASS_R,
        RESP
    } state_t;

    localparam logic [1:0] AXI_OKAY    = 2'b00;
    localparam logic [1:0] AXI_SLVERR  = 2'b10;
    localparam logic [1:0] AXI_INCR    = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    function automatic int unsigned offset_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned index_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned line_bytes,
                                             input int unsigned num_lines);
        return 32 - $clog2(line_bytes) - $clog2(num_lines);
    endfunction

    // Word-select width; kept at least 1 so single-word lines still elaborate.
    function automatic int unsigned word_bits(input int unsigned line_bytes);
        return (line_bytes > 4) ? $clog2(line_bytes / 4) : 1;
    endfunction

endpackage

// File: rtl/ysyx_25040129_icache_data_array.sv
// rtl/ysyx_25040129_icache_data_array.sv - line data storage with one sync write and one async read port
// Purpose: NUM_LINES x WORDS x 32-bit register array holding cached instructions.
// Ports:   clk                      - clock, rising edge
//          i_we/i_widx/i_wword      - write enable, line index and word slot
//          i_wdata                  - word to store
//          i_ridx/i_rword           - read line index and word slot
//          o_rdata                  - combinational read data
module ysyx_25040129_icache_data_array #(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned WORDS     = 4,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned WB_W      = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [WB_W-1:0]  i_wword,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    input  logic [WB_W-1:0]  i_rword,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [NUM_LINES][WORDS];

    // Contents are only meaningful behind a valid bit, so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx][i_wword] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx][i_rword];

endmodule

// File: rtl/ysyx_25040129_icache.sv
// rtl/ysyx_25040129_icache.sv - direct-mapped blocking instruction cache between IFU and AXI4 bus
// Purpose: serves IFU fetches from a direct-mapped array, refills misses with an
//          INCR burst, bypasses an uncached region with single-beat reads and
//          invalidates all lines on fence_i.
// Ports:   clk, rst (async, active-low)
//          araddr/arvalid/arready, rdata/rresp/rvalid/rready - IFU slave side
//          fence_i                                           - invalidate pulse
//          mem_ar*/mem_r*                                    - AXI4 read master
//          hit_cnt/miss_cnt                                  - wrapping statistics
module ysyx_25040129_icache
    import ysyx_25040129_icache_pkg::*;
#(
    parameter int unsigned LINE_BYTES    = 16,
    parameter int unsigned NUM_LINES     = 16,
    parameter logic [31:0] UNCACHED_BASE = 32'hA000_0000,
    parameter logic [31:0] UNCACHED_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        fence_i,
    output logic [31:0] mem_araddr,
    output logic [7:0]  mem_arlen,
    output logic [2:0]  mem_arsize,
    output logic [1:0]  mem_arburst,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rlast,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned WORDS = LINE_BYTES / 4;
    localparam int unsigned OFF_W = offset_bits(LINE_BYTES);
    localparam int unsigned IDX_W = index_bits(NUM_LINES);
    localparam int unsigned TAG_W = tag_bits(LINE_BYTES, NUM_LINES);
    localparam int unsigned WB_W  = word_bits(LINE_BYTES);
    localparam logic [7:0]  LAST_BEAT = 8'(WORDS - 1);

    state_t             r_state, w_next;
    logic [31:0]        r_addr;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [NUM_LINES];
    logic [7:0]         r_beat;
    logic [1:0]         r_err;
    logic               r_nofill;
    logic [31:0]        r_resp_data;
    logic [31:0]        r_hit_cnt;
    logic [31:0]        r_miss_cnt;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [WB_W-1:0]    w_word;
    logic               w_hit;
    logic               w_uncached;
    logic               w_refill_beat;
    logic [1:0]         w_err_after;
    logic               w_fill;
    logic [31:0]        w_arr_word;

    assign w_idx      = r_addr[OFF_W +: IDX_W];
    assign w_tag      = r_addr[31 -: TAG_W];
    assign w_word     = (WORDS == 1) ? '0 : r_addr[2 +: WB_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uncached = (araddr & UNCACHED_MASK) == UNCACHED_BASE;

    assign w_refill_beat = (r_state == REFILL_R) && mem_rvalid;

    // Error state after the current refill beat: the first bad response wins;
    // otherwise an rlast on any beat but the last expected one (early, or late
    // once the counter has run past it) is reported as SLVERR.
    always_comb begin
        w_err_after = r_err;
        if (r_err == AXI_OKAY) begin
            if (mem_rresp != AXI_OKAY) begin
                w_err_after = mem_rresp;
            end else if (mem_rlast && (r_beat != LAST_BEAT)) begin
                w_err_after = AXI_SLVERR;
            end
        end
    end

    // A fence in the final beat's cycle also suppresses the fill.
    assign w_fill = w_refill_beat && mem_rlast && (w_err_after == AXI_OKAY)
                    && !r_nofill && !fence_i;

    ysyx_25040129_icache_data_array #(
        .NUM_LINES (NUM_LINES),
        .WORDS     (WORDS),
        .IDX_W     (IDX_W),
        .WB_W      (WB_W)
    ) u_data_array (
        .clk     (clk),
        .i_we    (w_refill_beat && (r_beat < 8'(WORDS))),
        .i_widx  (w_idx),
        .i_wword (r_beat[WB_W-1:0]),
        .i_wdata (mem_rdata),
        .i_ridx  (w_idx),
        .i_rword (w_word),
        .o_rdata (w_arr_word)
    );

    assign mem_arsize  = AXI_SIZE_4B;
    assign mem_arburst = AXI_INCR;
    assign hit_cnt     = r_hit_cnt;
    assign miss_cnt    = r_miss_cnt;

    always_comb begin
        w_next      = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rdata       = r_resp_data;
        rresp       = r_err;
        mem_arvalid = 1'b0;
        mem_araddr  = 32'h0;
        mem_arlen   = 8'h0;
        mem_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    w_next = w_uncached ? BYPASS_AR : LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    rvalid = 1'b1;
                    rdata  = w_arr_word;
                    rresp  = AXI_OKAY;
                    w_next = rready ? IDLE : RESP;
                end else begin
                    w_next = REFILL_AR;
                end
            end
            REFILL_AR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
                mem_arlen   = LAST_BEAT;
                if (mem_arready) begin
                    w_next = REFILL_R;
                end
            end
            REFILL_R: begin
                mem_rready = 1'b1;
                if (mem_rvalid && mem_rlast) begin
                    w_next = RESP;
                end
            end
            BYPASS_AR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = {r_addr[31:2], 2'b00};
                if (mem_arready) begin
                    w_next = BYPASS_R;
                end
            end
            BYPASS_R: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= 32'h0;
            r_valid     <= '0;
            r_beat      <= 8'h0;
            r_err       <= AXI_OKAY;
            r_nofill    <= 1'b0;
            r_resp_data <= 32'h0;
            r_hit_cnt   <= 32'h0;
            r_miss_cnt  <= 32'h0;
        end else begin
            r_state <= w_next;

            if ((r_state == IDLE) && arvalid) begin
                r_addr <= araddr;
            end

            if (fence_i) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end

            if (r_state == LOOKUP) begin
                r_nofill <= 1'b0;
            end else if (fence_i && ((r_state == REFILL_AR) || (r_state == REFILL_R))) begin
                r_nofill <= 1'b1;
            end

            // Counter saturates so a runaway burst cannot alias back to a valid beat.
            if (r_state == REFILL_AR) begin
                r_beat <= 8'h0;
            end else if (w_refill_beat && (r_beat != 8'hFF)) begin
                r_beat <= r_beat + 8'h1;
            end

            if (w_refill_beat) begin
                r_err <= w_err_after;
            end else if ((r_state == BYPASS_R) && mem_rvalid) begin
                r_err <= mem_rresp;
            end else if ((r_state == RESP) && rready) begin
                r_err <= AXI_OKAY;
            end

            if ((r_state == LOOKUP) && w_hit) begin
                r_resp_data <= w_arr_word;
            end else if (w_refill_beat && (r_beat == 8'(w_word))) begin
                r_resp_data <= mem_rdata;
            end else if ((r_state == BYPASS_R) && mem_rvalid) begin
                r_resp_data <= mem_rdata;
            end

            if ((r_state == LOOKUP) && w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'h1;
            end
            if ((r_state == LOOKUP) && !w_hit) begin
                r_miss_cnt <= r_miss_cnt + 32'h1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx] <= w_tag;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_icache.sv
// tb/tb_ysyx_25040129_icache.sv - directed self-checking bench for the instruction cache
module tb_ysyx_25040129_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        fence_i;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int ar_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_arvalid) ar_cycles++;
    end

    ysyx_25040129_icache dut (
        .clk         (clk),
        .rst         (rst),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready),
        .fence_i     (fence_i),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arsize  (mem_arsize),
        .mem_arburst (mem_arburst),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rlast   (mem_rlast),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the handshake.
    task automatic ifu_req(input string tag, input logic [31:0] addr);
        araddr  = addr;
        arvalid = 1'b1;
        check({tag, " arready"}, 32'(arready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    // Bus slave: beat i carries seed*(i+1); optional error beat and fence beat.
    task automatic mem_serve(input string tag, input logic [31:0] exp_addr,
                             input logic [7:0] exp_len, input int nbeats,
                             input logic [31:0] seed, input int err_beat,
                             input int fence_beat);
        int n = 0;
        while (!mem_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " mem_arvalid"}, 32'(mem_arvalid), 32'h1);
        check({tag, " mem_araddr"}, mem_araddr, exp_addr);
        check({tag, " mem_arlen"}, 32'(mem_arlen), 32'(exp_len));
        check({tag, " mem_arsize/burst"}, {27'h0, mem_arsize, mem_arburst}, 32'b010_01);
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = seed * 32'(i + 1);
            mem_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            mem_rlast  = (i == nbeats - 1);
            fence_i    = (i == fence_beat);
            if (i == 0) check({tag, " mem_rready"}, 32'(mem_rready), 32'h1);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rresp  = 2'b00;
        fence_i    = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rvalid"}, 32'(rvalid), 32'h1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic fetch_miss(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_ar, input logic [7:0] exp_len,
                              input int nbeats, input logic [31:0] seed,
                              input int err_beat, input int fence_beat,
                              input logic [31:0] exp_data, input logic [1:0] exp_resp);
        ifu_req(tag, addr);
        check({tag, " no early rvalid"}, 32'(rvalid), 32'h0);
        mem_serve(tag, exp_ar, exp_len, nbeats, seed, err_beat, fence_beat);
        wait_resp(tag, exp_data, exp_resp);
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        int a0 = ar_cycles;
        ifu_req(tag, addr);
        check({tag, " rvalid@1"}, 32'(rvalid), 32'h1);
        check({tag, " rdata"}, rdata, exp_data);
        check({tag, " rresp"}, 32'(rresp), 32'h0);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check({tag, " no bus read"}, 32'(ar_cycles - a0), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        rst = 1'b0; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0; fence_i = 1'b0;
        mem_arready = 1'b0; mem_rdata = 32'h0; mem_rresp = 2'b00; mem_rlast = 1'b0; mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rvalid", 32'(rvalid), 32'h0);
        check("reset mem_arvalid", 32'(mem_arvalid), 32'h0);
        check("reset mem_rready", 32'(mem_rready), 32'h0);
        check("reset hit_cnt", hit_cnt, 32'h0);
        check("reset miss_cnt", miss_cnt, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("idle arready", 32'(arready), 32'h1);

        // Cold miss, then a hit on the refilled line.
        fetch_miss("t1", 32'h8000_0000, 32'h8000_0000, 8'd3, 4, 32'h11, -1, -1, 32'h11, 2'b00);
        check("t1 miss_cnt", miss_cnt, 32'd1);
        fetch_hit("t2", 32'h8000_0008, 32'h33);
        check("t2 hit_cnt", hit_cnt, 32'd1);

        // Conflicting tag on index 0 evicts, then the original line comes back.
        fetch_miss("t3a", 32'h8000_0100, 32'h8000_0100, 8'd3, 4, 32'h55, -1, -1, 32'h55, 2'b00);
        fetch_miss("t3b", 32'h8000_0000, 32'h8000_0000, 8'd3, 4, 32'h11, -1, -1, 32'h11, 2'b00);
        check("t3 miss_cnt", miss_cnt, 32'd3);

        // Hit held by IFU backpressure.
        ifu_req("t4", 32'h8000_0004);
        for (int i = 0; i < 5; i++) begin
            check("t4 rvalid held", 32'(rvalid), 32'h1);
            check("t4 rdata held", rdata, 32'h22);
            check("t4 rresp held", 32'(rresp), 32'h0);
            check("t4 arready low", 32'(arready), 32'h0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("t4 hit_cnt", hit_cnt, 32'd2);

        // Fence during the refill: response intact, line not kept, other lines cleared.
        fetch_miss("t5a", 32'h8000_0010, 32'h8000_0010, 8'd3, 4, 32'h60, -1, 2, 32'h60, 2'b00);
        fetch_miss("t5b", 32'h8000_0010, 32'h8000_0010, 8'd3, 4, 32'h70, -1, -1, 32'h70, 2'b00);
        fetch_miss("t5c", 32'h8000_0000, 32'h8000_0000, 8'd3, 4, 32'h11, -1, -1, 32'h11, 2'b00);
        check("t5 miss_cnt", miss_cnt, 32'd6);

        // Bus error on the first beat: error reported, line stays invalid.
        fetch_miss("t6a", 32'h8000_0020, 32'h8000_0020, 8'd3, 4, 32'h90, 0, -1, 32'h90, 2'b10);
        fetch_miss("t6b", 32'h8000_0020, 32'h8000_0020, 8'd3, 4, 32'h90, -1, -1, 32'h90, 2'b00);
        fetch_hit("t6c", 32'h8000_002C, 32'h240);
        check("t6 miss_cnt", miss_cnt, 32'd8);
        check("t6 hit_cnt", hit_cnt, 32'd3);

        // Early rlast after two beats counts as SLVERR and leaves the line invalid.
        fetch_miss("t7a", 32'h8000_0030, 32'h8000_0030, 8'd3, 2, 32'h31, -1, -1, 32'h31, 2'b10);
        fetch_miss("t7b", 32'h8000_0034, 32'h8000_0030, 8'd3, 4, 32'h41, -1, -1, 32'h82, 2'b00);
        check("t7 miss_cnt", miss_cnt, 32'd10);

        // Uncached region: single-beat read every time, counters untouched.
        fetch_miss("t8a", 32'hA000_0004, 32'hA000_0004, 8'd0, 1, 32'hDEAD_BEEF, -1, -1, 32'hDEAD_BEEF, 2'b00);
        a0 = ar_cycles;
        fetch_miss("t8b", 32'hA000_0004, 32'hA000_0004, 8'd0, 1, 32'hCAFE_F00D, -1, -1, 32'hCAFE_F00D, 2'b00);
        check("t8 repeat bus read", 32'(ar_cycles - a0 > 0), 32'h1);
        check("t8 miss_cnt", miss_cnt, 32'd10);
        check("t8 hit_cnt", hit_cnt, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
